// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package ula_pkg;

    localparam int W_DEFAULT = 6;

    // Arithmetic opcodes (alu_modo = 0)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;

    // Logic opcodes (alu_modo = 1)
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;

    // Encodings double as the state_dbg value
    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Settle counter width; a one-cycle settle still needs a 1-bit counter
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/ula_edge_detect.sv
// Rising-edge detector for the debounced enter key.
module ula_edge_detect (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic r_level_q;

    // The delayed copy keeps tracking the key through reset, so a key held
    // across reset release is not mistaken for a fresh press.
    always_ff @(posedge CLOCK_50) begin
        r_level_q <= level;
    end

    assign pulse = level & ~r_level_q & ~reset;

endmodule

// File: rtl/ula_sequencer.sv
// Loads A, B and opcode on successive key presses, holds them stable for the
// ALU to settle, then captures and displays the ALU outputs.
//
// state      | meaning
// LOAD_A     | waiting for press to load operand A
// LOAD_B     | waiting for press to load operand B
// LOAD_OP    | waiting for press to load opcode and class
// WAIT       | operands held, counting settle cycles
// DONE       | captured result displayed, press returns to LOAD_A
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int W             = W_DEFAULT
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         modo_in,
    input  logic         enter,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_modo,
    input  logic [W-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    output logic [W-1:0] res,
    output logic         res_overflow,
    output logic         res_zero,
    output logic         res_valid,
    output logic         busy,
    output logic [2:0]   state_dbg
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_alu_modo;
    logic [W-1:0]     r_res;
    logic             r_res_overflow;
    logic             r_res_zero;
    logic             r_res_valid;
    logic             r_busy;
    logic             w_press;

    ula_edge_detect u_edge (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .level    (enter),
        .pulse    (w_press)
    );

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state        <= ST_LOAD_A;
            r_cnt          <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_modo     <= 1'b0;
            r_res          <= '0;
            r_res_overflow <= 1'b0;
            r_res_zero     <= 1'b0;
            r_res_valid    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_press) begin
                        r_alu_a <= data_in;
                        r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_press) begin
                        r_alu_b <= data_in;
                        r_state <= ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (w_press) begin
                        r_alu_op   <= data_in[2:0];
                        r_alu_modo <= modo_in;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Presses are dropped here; nothing is remembered for later.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_res          <= alu_result;
                        r_res_overflow <= alu_overflow;
                        r_res_zero     <= alu_zero;
                        r_res_valid    <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_press) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_LOAD_A;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_LOAD_A;
                end
            endcase
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign alu_modo     = r_alu_modo;
    assign res          = r_res;
    assign res_overflow = r_res_overflow;
    assign res_zero     = r_res_zero;
    assign res_valid    = r_res_valid;
    assign busy         = r_busy;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer with a behavioural settling ALU.
module tb_ula_sequencer;

    localparam int W = 6;
    localparam int S = 3;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b1;
    logic [W-1:0] data_in  = '0;
    logic         modo_in  = 1'b0;
    logic         enter    = 1'b0;
    logic [W-1:0] alu_a, alu_b, res;
    logic [2:0]   alu_op, state_dbg;
    logic         alu_modo, res_overflow, res_zero, res_valid, busy;
    logic [W-1:0] m_res  = '0;
    logic         m_ov   = 1'b0;
    logic         m_zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    ula_sequencer #(.SETTLE_CYCLES(S), .W(W)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .data_in      (data_in),
        .modo_in      (modo_in),
        .enter        (enter),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_modo     (alu_modo),
        .alu_result   (m_res),
        .alu_overflow (m_ov),
        .alu_zero     (m_zero),
        .res          (res),
        .res_overflow (res_overflow),
        .res_zero     (res_zero),
        .res_valid    (res_valid),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Behavioural ALU: {zero, overflow, result}
    function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op, input logic modo);
        logic [W:0]   t;
        logic [W-1:0] r;
        t = '0;
        if (modo) begin
            case (op)
                3'd0:    r = a & b;
                3'd1:    r = a | b;
                3'd2:    r = a ^ b;
                3'd3:    r = ~a;
                default: r = a;
            endcase
            t = {1'b0, r};
        end else begin
            case (op)
                3'd0:    t = {1'b0, a} + {1'b0, b};
                3'd1:    t = {1'b0, a} - {1'b0, b};
                3'd2:    t = {1'b0, a} + 7'd1;
                3'd3:    t = {1'b0, a} - 7'd1;
                default: t = {1'b0, a};
            endcase
        end
        return {(t[W-1:0] == '0), t[W], t[W-1:0]};
    endfunction

    // Outputs are only correct once the inputs have been stable for S cycles;
    // before that the model drives the inverted answer.
    logic [15:0]  snap = '0;
    int           age  = 0;
    logic [W+1:0] f;
    always @(posedge CLOCK_50) begin
        #1;
        if ({alu_a, alu_b, alu_op, alu_modo} != snap) begin
            snap = {alu_a, alu_b, alu_op, alu_modo};
            age  = 0;
        end else if (age < 1000) begin
            age = age + 1;
        end
        f = alu_fn(alu_a, alu_b, alu_op, alu_modo);
        if (age >= S - 1) {m_zero, m_ov, m_res} = f;
        else              {m_zero, m_ov, m_res} = ~f;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         modo;
        logic [W-1:0] res;
        logic         ov;
        logic         zero;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];
    vec_t e;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [W-1:0] d, input logic m);
        data_in = d;
        modo_in = m;
        enter   = 1'b1;
        @(negedge CLOCK_50);
        enter   = 1'b0;
    endtask

    task automatic idle();
        @(negedge CLOCK_50);
    endtask

    initial begin
        vecs[0] = '{6'd5,  6'd8,  3'd0, 1'b0, 6'd13, 1'b0, 1'b0};
        vecs[1] = '{6'd63, 6'd1,  3'd0, 1'b0, 6'd0,  1'b1, 1'b1};
        vecs[2] = '{6'h2A, 6'h15, 3'd0, 1'b1, 6'd0,  1'b0, 1'b1};
        vecs[3] = '{6'd20, 6'd7,  3'd1, 1'b0, 6'd13, 1'b0, 1'b0};
        vecs[4] = '{6'd3,  6'd5,  3'd1, 1'b0, 6'd62, 1'b1, 1'b0};
        vecs[5] = '{6'h2A, 6'h15, 3'd1, 1'b1, 6'd63, 1'b0, 1'b0};
        vecs[6] = '{6'h33, 6'h0F, 3'd2, 1'b1, 6'd60, 1'b0, 1'b0};
        vecs[7] = '{6'd10, 6'd0,  3'd3, 1'b0, 6'd9,  1'b0, 1'b0};

        // Reset state
        reset = 1'b1;
        idle();
        idle();
        chk("rst_state", state_dbg, 0);
        chk("rst_outs", {alu_a, alu_b, alu_op, alu_modo, res, res_overflow, res_zero,
                         res_valid, busy}, 0);
        reset = 1'b0;
        idle();

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].a, 1'b0);
            chk("load_a_state", state_dbg, 1);
            idle();
            press(vecs[i].b, 1'b0);
            chk("load_b_state", state_dbg, 2);
            idle();
            press({3'b101, vecs[i].op}, vecs[i].modo);
            sb_q.push_back(vecs[i]);
            for (int k = 1; k <= S + 1; k++) begin
                if (k <= S) begin
                    chk("wait_state", state_dbg, 3);
                    chk("wait_busy", busy, 1);
                    chk("wait_valid", res_valid, 0);
                    chk("wait_hold", {alu_a, alu_b, alu_op, alu_modo},
                        {vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].modo});
                    // Vector 0 also gets a stray press in the middle of WAIT
                    if (i == 0 && k == 2) enter = 1'b1;
                    if (k == 3) enter = 1'b0;
                    idle();
                end else begin
                    chk("done_valid", res_valid, 1);
                    chk("done_busy", busy, 0);
                    chk("done_state", state_dbg, 4);
                    if (res_valid && sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("res", res, e.res);
                        chk("res_overflow", res_overflow, e.ov);
                        chk("res_zero", res_zero, e.zero);
                    end else begin
                        chk("sb_pop", res_valid, 1);
                        if (sb_q.size() > 0) void'(sb_q.pop_front());
                    end
                end
            end
            idle();
            chk("done_stays", state_dbg, 4);
            press(6'd0, 1'b0);
            chk("exit_state", state_dbg, 0);
            chk("exit_valid", res_valid, 0);
            chk("exit_res_kept", {res, res_overflow, res_zero},
                {vecs[i].res, vecs[i].ov, vecs[i].zero});
            chk("exit_ops_kept", {alu_a, alu_b, alu_op},
                {vecs[i].a, vecs[i].b, vecs[i].op});
            idle();
        end

        // Reset in WAIT at cnt=1, together with a rising enter
        press(6'd7, 1'b0);
        idle();
        press(6'd9, 1'b0);
        idle();
        press(6'd0, 1'b0);
        idle();
        reset = 1'b1;
        enter = 1'b1;
        idle();
        chk("abort_state", state_dbg, 0);
        chk("abort_outs", {alu_a, alu_b, alu_op, alu_modo, res, res_overflow, res_zero,
                           res_valid, busy}, 0);
        reset = 1'b0;
        data_in = 6'd33;
        for (int k = 0; k < S + 2; k++) idle();
        chk("held_no_press_state", state_dbg, 0);
        chk("held_no_press_a", alu_a, 0);
        chk("abort_no_capture", {res, res_valid}, 0);
        enter = 1'b0;
        idle();
        press(6'd21, 1'b0);
        chk("reload_state", state_dbg, 1);
        chk("reload_a", alu_a, 21);
        idle();

        // Key held for several cycles yields a single press
        data_in = 6'd44;
        enter   = 1'b1;
        for (int k = 0; k < 4; k++) idle();
        chk("held_one_press_state", state_dbg, 2);
        chk("held_one_press_b", alu_b, 44);
        enter = 1'b0;
        idle();

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ula_sequencer.md
ULA_SEQUENCER -- requirements
Module: ula_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 3, number of cycles the ALU inputs are held stable before its outputs are captured; legal range 1..15.
REQ-002 Parameter: W, default 6, operand/result width.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 data_in  in  W  operand value (A or B), or opcode in data_in[2:0].
REQ-006 modo_in  in  1  operation class: 1 = logic, 0 = arithmetic.
REQ-007 enter  in  1  level from a debounced key; its rising edge is a "press".
REQ-008 alu_a, alu_b  out  W each  operands driven to the ALU.
REQ-009 alu_op  out  3  opcode driven to the ALU; alu_modo  out  1  class driven to the ALU.
REQ-010 alu_result  in  W; alu_overflow  in  1; alu_zero  in  1  ALU outputs.
REQ-011 res  out  W; res_overflow  out  1; res_zero  out  1  captured ALU outputs.
REQ-012 res_valid  out  1  high while captured outputs are displayed.
REQ-013 busy  out  1  high while in WAIT; state_dbg  out  3  current state encoding.

Function
REQ-014 Press = enter & ~enter_q, where enter_q is enter registered every cycle, including during reset.
REQ-015 The FSM SHALL have the states LOAD_A, LOAD_B, LOAD_OP, WAIT and DONE.
REQ-016 LOAD_A + press: alu_a <= data_in; next state LOAD_B. With no press, the FSM stays in LOAD_A.
REQ-017 LOAD_B + press: alu_b <= data_in; next state LOAD_OP.
REQ-018 LOAD_OP + press: alu_op <= data_in[2:0]; alu_modo <= modo_in; cnt <= 0; next state WAIT.
REQ-019 WAIT: cnt increments each cycle; alu_a, alu_b, alu_op and alu_modo SHALL NOT change.
REQ-020 WAIT with cnt == SETTLE_CYCLES-1: res, res_overflow and res_zero <= the ALU outputs; next state DONE.
REQ-021 Latency: for a LOAD_OP press in cycle t, res_valid rises in cycle t+SETTLE_CYCLES+1.
REQ-022 res_valid = 1 only in DONE.
REQ-023 busy = 1 only in WAIT.
REQ-024 DONE + press: next state LOAD_A; res_valid falls the next cycle.
REQ-025 On leaving DONE, res, res_overflow and res_zero SHALL keep their values until the next capture.
REQ-026 alu_a, alu_b, alu_op and alu_modo SHALL keep their values after a capture, until each is reloaded.
REQ-027 A press during WAIT SHALL be ignored and SHALL NOT be queued.
REQ-028 enter held high SHALL produce exactly one press.
REQ-029 alu_* and res* SHALL be driven directly from registers; there is no combinational path from inputs to outputs.
REQ-030 state_dbg encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, WAIT=3, DONE=4.

Reset
REQ-031 While reset=1 at a clock edge: state <= LOAD_A; cnt <= 0; all outputs <= 0.
REQ-032 reset=1 SHALL take priority over a press in the same cycle.
REQ-033 Reset asserted mid-WAIT or in DONE SHALL abort the operation with no capture.
REQ-034 With enter held high through reset release, no press SHALL be generated until enter falls and rises again.

Structure
REQ-035 Shared package ula_pkg SHALL hold the state enum, the ALU opcode constants (logic and arithmetic, 3 bits each) and the default width W=6.
REQ-036 The rising-edge detector SHALL be a sub-module, ula_edge_detect (inputs CLOCK_50, reset, level; output pulse).
REQ-037 The counter width SHALL be sized from SETTLE_CYCLES with $clog2.

Verification
REQ-038 The bench SHALL use a behavioural ALU model with latency SETTLE_CYCLES.
REQ-039 Scenario 1: presses with data 5, 8, op=000, modo=0 -> res=13, res_overflow=0, res_zero=0; res_valid high at cycle t+SETTLE_CYCLES+1.
REQ-040 Scenario 2: A=63, B=1, op=000, modo=0 -> res=0, res_overflow=1, res_zero=1.
REQ-041 Scenario 3: A=0x2A, B=0x15, op=000, modo=1 (AND) -> res=0, res_zero=1; then a press in DONE -> state_dbg=0 and res_valid=0 next cycle, with res still 0.
REQ-042 Scenario 4: extra press during WAIT -> ignored; state reaches DONE on schedule, and alu_a, alu_b, alu_op stay stable throughout WAIT.
REQ-043 Scenario 5: reset pulsed in WAIT (cnt=1) -> LOAD_A, all outputs 0, no capture; enter held high across reset release -> no load until the next rising edge.
